receiver: RTL and testbench
===========================

RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter: OSR, 16, clk_en ticks per bit; fixed, and no other value SHALL be supported.
REQ-002 clk_in  input  1  system clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 clk_en  input  1  oversample tick, 16x baud, one clk_in cycle wide; frame logic SHALL advance only on clk_en cycles.
REQ-005 rx_in  input  1  asynchronous serial line, 8N1, idle high, LSB first.
REQ-006 read_ack  input  1  consumer acknowledge; clears data_valid_o and overrun_o.
REQ-007 data_o  output  8  last correctly framed byte.
REQ-008 data_valid_o  output  1  level; high while data_o holds an unacknowledged byte.
REQ-009 frame_err_o  output  1  one clk_in pulse on bad stop bit.
REQ-010 overrun_o  output  1  sticky; a byte completed while data_valid_o was already high.
REQ-011 busy_o  output  1  high whenever the state is not IDLE.

Function
REQ-012 rx_in SHALL pass through a 2-flop synchronizer clocked every clk_in cycle, independent of clk_en; both flops reset to 1.
REQ-013 States SHALL be IDLE and FRAME; a tick counter t (8 bits) SHALL count clk_en cycles within FRAME.
REQ-014 IDLE: a prev-sample register SHALL be loaded with the synchronized rx on each clk_en.
REQ-015 IDLE: on a clk_en cycle with synchronized rx = 0 and prev = 1, the FSM SHALL enter FRAME with t = 0.
REQ-016 Bit n (start = 0, data = 1..8, stop = 9) SHALL be sampled at t = 16n+6, 16n+7 and 16n+8; the bit value is the 2-of-3 majority, decided at t = 16n+8.
REQ-017 Start bit majority = 1 at t = 8: false start; the FSM SHALL return to IDLE with no output change.
REQ-018 Data bits SHALL shift into an 8-bit shift register LSB first.
REQ-019 Stop decision at t = 152: the FSM SHALL return to IDLE on the same clk_en, so a new start edge is accepted from the next clk_en.
REQ-020 Stop = 1: data_o SHALL load the shift register and data_valid_o SHALL be 1 from the following clk_in cycle.
REQ-021 Stop = 1 while data_valid_o = 1 and read_ack = 0: overrun_o SHALL set to 1, and data_o SHALL be overwritten with the new byte.
REQ-022 Stop = 1 with read_ack = 1 on the same cycle: the new byte wins; data_valid_o stays 1 and overrun_o is not set.
REQ-023 Stop = 0: frame_err_o SHALL pulse high for exactly one clk_in cycle; data_o, data_valid_o and overrun_o are unchanged.
REQ-024 read_ack SHALL be honoured on any clk_in cycle regardless of clk_en, clearing data_valid_o and overrun_o on the next edge.
REQ-025 With clk_en = 0, state, t, prev and the shift register SHALL hold.
REQ-026 busy_o SHALL be decoded from state, with no added latency.

Reset
REQ-027 Reset SHALL force: state = IDLE, t = 0, shift register = 0, data_o = 0x00, data_valid_o = 0, frame_err_o = 0, overrun_o = 0, busy_o = 0.
REQ-028 Reset SHALL force prev = 0, so a line held low through or after reset never triggers a frame until it has been sampled high.
REQ-029 Reset SHALL take priority over clk_en and read_ack; reset mid-frame SHALL abort the frame with no data_valid_o or frame_err_o.

Verification
REQ-030 clk_en every cycle, send 0xA5 with 16 ticks/bit -> data_o = 0xA5, data_valid_o = 1 after stop decision, frame_err_o never high, busy_o low after t = 152.
REQ-031 rx_in low for 4 ticks then high -> false start at t = 8, busy_o drops, data_valid_o = 0, frame_err_o = 0.
REQ-032 Send 0x3C with stop bit driven 0 -> single-cycle frame_err_o pulse, data_valid_o = 0, data_o = 0x00.
REQ-033 Send 0x11 then 0x22 back-to-back with no read_ack -> data_o = 0x22, overrun_o = 1; one read_ack -> data_valid_o = 0 and overrun_o = 0.
REQ-034 Reset during data bit 4 of 0xFF, rx_in held low afterwards, then released high -> all outputs 0, no frame started until rx_in goes high then low.
REQ-035 clk_en every 4th clk_in, send 0x5A with one-sample glitches mid-bit -> data_o = 0x5A via majority vote; read_ack during clk_en-low cycles clears data_valid_o.

Source files
------------

// File: rtl/receiver.sv
// UART-style 8N1 receiver with 16x oversampling and 2-of-3 majority voting.
// A finished byte is held in data_o until the consumer acknowledges it.
// A bad stop bit gives a one-cycle frame error pulse.
// A byte that lands on an unacknowledged byte sets a sticky overrun flag.
`timescale 1ns/1ps

module receiver #(
  parameter int OSR = 16
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       rx_in,
  input  logic       read_ack,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  // Bit timing assumes OSR = 16.
  // The low nibble of t is the phase within a bit.
  // The high nibble of t is the bit index.
  localparam logic [3:0] PH_A = 4'(OSR / 2 - 2);
  localparam logic [3:0] PH_B = 4'(OSR / 2 - 1);
  localparam logic [3:0] PH_C = 4'(OSR / 2);
  localparam logic [3:0] STOP_IDX = 4'd9;

  typedef enum logic {
    IDLE,
    FRAME
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  t;
  logic [7:0]  t_next;
  logic        rx_meta;
  logic        rx_sync;
  logic        prev;
  logic        sample_a;
  logic        sample_b;
  logic        majority;
  logic [7:0]  shift_reg;
  logic [3:0]  phase;
  logic [3:0]  bit_idx;
  logic        capture_a;
  logic        capture_b;
  logic        shift_en;
  logic        byte_good;
  logic        byte_bad;

  assign phase    = t[3:0];
  assign bit_idx  = t[7:4];
  assign majority = (sample_a & sample_b) | (sample_a & rx_sync) | (sample_b & rx_sync);

  // Two-flop synchronizer on the raw line, running every clk_in cycle.
  // Both flops reset to 1, so they read "high" for two cycles after reset.
  // A clk_en that arrives in that window will load prev with that high.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
    end
  end

  // State and tick counter register.
  // t_next already equals t on non-clk_en cycles, so both hold then.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= IDLE;
      t     <= 8'd0;
    end else begin
      state <= next_state;
      t     <= t_next;
    end
  end

  // Next-state logic plus the per-tick control strobes.
  // Frames start on a falling edge seen between two idle ticks.
  // Each bit is decided at its third vote sample.
  always_comb begin
    next_state = state;
    t_next     = t;
    capture_a  = 1'b0;
    capture_b  = 1'b0;
    shift_en   = 1'b0;
    byte_good  = 1'b0;
    byte_bad   = 1'b0;
    busy_o     = (state != IDLE);
    case (state)
      IDLE: begin
        if (clk_en && !rx_sync && prev) begin
          next_state = FRAME;
          t_next     = 8'd0;
        end
      end
      FRAME: begin
        if (clk_en) begin
          t_next    = t + 8'd1;
          capture_a = (phase == PH_A);
          capture_b = (phase == PH_B);
          if (phase == PH_C) begin
            if (bit_idx == 4'd0) begin
              if (majority) begin
                next_state = IDLE;
                t_next     = 8'd0;
              end
            end else if (bit_idx == STOP_IDX) begin
              next_state = IDLE;
              t_next     = 8'd0;
              byte_good  = majority;
              byte_bad   = !majority;
            end else begin
              shift_en = 1'b1;
            end
          end
        end
      end
      default: begin
        next_state = IDLE;
        t_next     = 8'd0;
      end
    endcase
  end

  // Previous-sample register for start-edge detection, updated only while idle.
  // It resets to 0 so that a line stuck low must first be seen high.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      prev <= 1'b0;
    end else if (clk_en && state == IDLE) begin
      prev <= rx_sync;
    end
  end

  // First two vote samples of the current bit.
  // The third vote is the live synchronized value at decision time.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sample_a <= 1'b0;
      sample_b <= 1'b0;
    end else begin
      if (capture_a) sample_a <= rx_sync;
      if (capture_b) sample_b <= rx_sync;
    end
  end

  // Data bits arrive LSB first.
  // Each bit enters at the top and moves down toward bit 0.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      shift_reg <= 8'd0;
    end else if (shift_en) begin
      shift_reg <= {majority, shift_reg[7:1]};
    end
  end

  // Consumer-facing outputs.
  // A good stop loads the byte and beats a same-cycle acknowledge.
  // Otherwise an acknowledge clears the valid and overrun flags on any cycle.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      data_o       <= 8'd0;
      data_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      frame_err_o <= byte_bad;
      if (byte_good) begin
        data_o       <= shift_reg;
        data_valid_o <= 1'b1;
        if (read_ack) begin
          overrun_o <= 1'b0;
        end else if (data_valid_o) begin
          overrun_o <= 1'b1;
        end
      end else if (read_ack) begin
        data_valid_o <= 1'b0;
        overrun_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Directed, self-checking bench for the receiver.
// Sent bytes are pushed onto a scoreboard queue and popped once each frame has finished.
`timescale 1ns/1ps

module tb_receiver;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       clk_en;
  logic       rx_in;
  logic       read_ack;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int         checks     = 0;
  int         failures   = 0;
  int         en_period  = 1;
  int         err_cycles = 0;
  bit         busy_seen  = 1'b0;
  logic [7:0] exp_q[$];

  receiver #(.OSR(16)) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .clk_en       (clk_en),
    .rx_in        (rx_in),
    .read_ack     (read_ack),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .busy_o       (busy_o)
  );

  // 100 MHz system clock.
  always #5 clk_in = ~clk_in;

  // One clk_in cycle.
  // Outputs are observed at the falling edge, then the next input values are driven.
  task automatic applyStimulus(input logic en, input logic rx, input logic ack);
    @(negedge clk_in);
    if (frame_err_o === 1'b1) err_cycles++;
    if (busy_o === 1'b1) busy_seen = 1'b1;
    clk_en   = en;
    rx_in    = rx;
    read_ack = ack;
  endtask

  // One oversample tick: a clk_en cycle followed by (en_period - 1) quiet cycles.
  task automatic tick(input logic rx);
    applyStimulus(1'b1, rx, 1'b0);
    repeat (en_period - 1) applyStimulus(1'b0, rx, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  // Pop the oldest expected byte and compare it against data_o.
  task automatic checkByte(input string tag);
    logic [7:0] exp_byte;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=queued_byte", tag, data_o);
    end else begin
      exp_byte = exp_q.pop_front();
      checkOutput(tag, data_o, exp_byte);
    end
  endtask

  // Send a full frame at 16 ticks per bit.
  // With glitch set, the middle tick of every bit is inverted.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch, input int idle);
    logic [9:0] bits;
    logic       v;
    bits = {stop, b, 1'b0};
    if (stop) exp_q.push_back(b);
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < 16; k++) begin
        v = bits[n];
        if (glitch && k == 8) v = ~v;
        tick(v);
      end
    end
    repeat (idle) tick(1'b1);
  endtask

  task automatic pulseAck();
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
  endtask

  // Directed test sequence.
  initial begin
    reset    = 1'b1;
    clk_en   = 1'b0;
    rx_in    = 1'b1;
    read_ack = 1'b0;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("reset_data",    data_o, 8'h00);
    checkOutput("reset_valid",   8'(data_valid_o), 8'h00);
    checkOutput("reset_ferr",    8'(frame_err_o), 8'h00);
    checkOutput("reset_overrun", 8'(overrun_o), 8'h00);
    checkOutput("reset_busy",    8'(busy_o), 8'h00);
    repeat (4) tick(1'b1);

    // False start: four low ticks, then the line returns high.
    err_cycles = 0;
    busy_seen  = 1'b0;
    repeat (4) tick(1'b0);
    repeat (20) tick(1'b1);
    checkOutput("fstart_busy_seen", 8'(busy_seen), 8'h01);
    checkOutput("fstart_busy",      8'(busy_o), 8'h00);
    checkOutput("fstart_valid",     8'(data_valid_o), 8'h00);
    checkOutput("fstart_ferr",      8'(err_cycles), 8'h00);

    // Bad stop bit.
    err_cycles = 0;
    send_frame(8'h3C, 1'b0, 1'b0, 4);
    checkOutput("badstop_ferr_cycles", 8'(err_cycles), 8'h01);
    checkOutput("badstop_valid",       8'(data_valid_o), 8'h00);
    checkOutput("badstop_data",        data_o, 8'h00);

    // Clean byte.
    err_cycles = 0;
    send_frame(8'hA5, 1'b1, 1'b0, 4);
    checkByte("a5_data");
    checkOutput("a5_valid",   8'(data_valid_o), 8'h01);
    checkOutput("a5_busy",    8'(busy_o), 8'h00);
    checkOutput("a5_ferr",    8'(err_cycles), 8'h00);
    checkOutput("a5_overrun", 8'(overrun_o), 8'h00);
    pulseAck();
    checkOutput("a5_ack_valid", 8'(data_valid_o), 8'h00);

    // Back-to-back bytes with no acknowledge.
    send_frame(8'h11, 1'b1, 1'b0, 0);
    checkByte("b2b_first");
    checkOutput("b2b_first_overrun", 8'(overrun_o), 8'h00);
    send_frame(8'h22, 1'b1, 1'b0, 4);
    checkByte("b2b_second");
    checkOutput("b2b_valid",   8'(data_valid_o), 8'h01);
    checkOutput("b2b_overrun", 8'(overrun_o), 8'h01);
    pulseAck();
    checkOutput("b2b_ack_valid",   8'(data_valid_o), 8'h00);
    checkOutput("b2b_ack_overrun", 8'(overrun_o), 8'h00);

    // Reset in the middle of an 0xFF frame, with the line held low afterwards.
    repeat (16) tick(1'b0);
    repeat (72) tick(1'b1);
    checkOutput("midreset_busy_before", 8'(busy_o), 8'h01);
    @(negedge clk_in);
    reset  = 1'b1;
    rx_in  = 1'b0;
    clk_en = 1'b1;
    repeat (2) @(negedge clk_in);
    reset  = 1'b0;
    clk_en = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midreset_data",    data_o, 8'h00);
    checkOutput("midreset_valid",   8'(data_valid_o), 8'h00);
    checkOutput("midreset_ferr",    8'(frame_err_o), 8'h00);
    checkOutput("midreset_overrun", 8'(overrun_o), 8'h00);
    checkOutput("midreset_busy",    8'(busy_o), 8'h00);
    busy_seen  = 1'b0;
    err_cycles = 0;
    repeat (40) tick(1'b0);
    checkOutput("lowhold_no_frame", 8'(busy_seen), 8'h00);
    repeat (6) tick(1'b1);
    checkOutput("release_no_frame", 8'(busy_seen), 8'h00);
    send_frame(8'h0F, 1'b1, 1'b0, 4);
    checkByte("post_reset_data");
    checkOutput("post_reset_ferr", 8'(err_cycles), 8'h00);
    pulseAck();

    // Sparse clk_en with one-sample glitches in the middle of each bit.
    en_period  = 4;
    err_cycles = 0;
    repeat (4) tick(1'b1);
    send_frame(8'h5A, 1'b1, 1'b1, 4);
    checkByte("glitch_data");
    checkOutput("glitch_valid", 8'(data_valid_o), 8'h01);
    checkOutput("glitch_ferr",  8'(err_cycles), 8'h00);
    pulseAck();
    checkOutput("glitch_ack_valid", 8'(data_valid_o), 8'h00);

    checkOutput("scoreboard_empty", 8'(exp_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
